// File: rtl/retry_pkg.sv
`default_nettype none
// ============================================================================
// retry_pkg : states, subtype codes and field offsets of RETRY control flits
// Revision  : 1.0
// ============================================================================
package retry_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    REQ   = 2'd2,
    ACK   = 2'd3
  } rcfp_state_e;

  localparam logic [3:0] LLCTRL_RETRY  = 4'h3;
  localparam logic [3:0] SUBTYPE_FRAME = 4'h3;
  localparam logic [3:0] SUBTYPE_REQ   = 4'h1;
  localparam logic [3:0] SUBTYPE_ACK   = 4'h2;

  // Bit offsets inside the flit; the unpacker decodes with the same values.
  localparam int CTRL_BIT          = 0;
  localparam int LLCTRL_LSB        = 4;
  localparam int SUBTYPE_LSB       = 8;
  localparam int REQ_NUM_RETRY_LSB = 32;
  localparam int REQ_NUM_PHY_LSB   = 40;
  localparam int REQ_ESEQ_LSB      = 48;
  localparam int ACK_EMPTY_BIT     = 32;
  localparam int ACK_NUM_RETRY_LSB = 33;
  localparam int ACK_NUM_PHY_LSB   = 40;
  localparam int ACK_WRT_PTR_LSB   = 48;
  localparam int ACK_FREE_BUFF_LSB = 56;

  typedef struct packed {
    logic [4:0] num_retry;
    logic [4:0] num_phy_reinit;
    logic [7:0] eseq;
    logic [7:0] wrt_ptr;
    logic [7:0] num_free_buff;
    logic       empty;
  } retry_snap_t;

  function automatic logic [3:0] subtype_of(input rcfp_state_e st);
    case (st)
      FRAME:   return SUBTYPE_FRAME;
      REQ:     return SUBTYPE_REQ;
      ACK:     return SUBTYPE_ACK;
      default: return 4'h0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/retry_ctrl_flit_fmt.sv
`default_nettype none
// ============================================================================
// retry_ctrl_flit_fmt : combinational assembly of one RETRY control flit
// Revision            : 1.0
// ============================================================================
module retry_ctrl_flit_fmt
  import retry_pkg::*;
#(
  parameter int FLIT_W = 512
) (
  input  logic              i_valid,
  input  logic [3:0]        i_subtype,
  input  retry_snap_t       i_snap,
  output logic [FLIT_W-1:0] o_flit
);

  always_comb begin
    o_flit = '0;
    if (i_valid) begin
      o_flit[CTRL_BIT]              = 1'b1;
      o_flit[LLCTRL_LSB +: 4]       = LLCTRL_RETRY;
      o_flit[SUBTYPE_LSB +: 4]      = i_subtype;
      case (i_subtype)
        SUBTYPE_REQ: begin
          o_flit[REQ_NUM_RETRY_LSB +: 5] = i_snap.num_retry;
          o_flit[REQ_NUM_PHY_LSB +: 5]   = i_snap.num_phy_reinit;
          o_flit[REQ_ESEQ_LSB +: 8]      = i_snap.eseq;
        end
        SUBTYPE_ACK: begin
          o_flit[ACK_EMPTY_BIT]          = i_snap.empty;
          o_flit[ACK_NUM_RETRY_LSB +: 5] = i_snap.num_retry;
          o_flit[ACK_NUM_PHY_LSB +: 5]   = i_snap.num_phy_reinit;
          o_flit[ACK_WRT_PTR_LSB +: 8]   = i_snap.wrt_ptr;
          o_flit[ACK_FREE_BUFF_LSB +: 8] = i_snap.num_free_buff;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/retry_ctrl_flit_packer.sv
`default_nettype none
// ============================================================================
// retry_ctrl_flit_packer : sequences RETRY.Frame x N + Req/Ack flits to the CRC
// Revision               : 1.0
// ============================================================================
module retry_ctrl_flit_packer
  import retry_pkg::*;
#(
  parameter int NUM_FRAMES = 5,
  parameter int FLIT_W     = 512
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pl_lnk_up,
  input  logic              retry_send_req_seq,
  input  logic              retry_send_ack_seq,
  input  logic [4:0]        retry_num_retry,
  input  logic [4:0]        retry_num_phy_reinit,
  input  logic [7:0]        retry_eseq,
  input  logic [7:0]        retry_wrt_ptr,
  input  logic [7:0]        retry_num_free_buff,
  input  logic              retry_set_ack_bit,
  input  logic              i_flit_ready,
  output logic              o_flit_valid,
  output logic [FLIT_W-1:0] o_flit,
  output logic              o_req_sent,
  output logic              o_ack_sent,
  output logic              o_busy
);

  localparam logic [3:0] LAST_FRAME = 4'(NUM_FRAMES - 1);

  rcfp_state_e state_q, state_d;
  rcfp_state_e cur_type_q, cur_type_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic        req_pend_q, req_pend_d;
  logic        ack_pend_q, ack_pend_d;
  retry_snap_t snap_q, snap_d;
  logic        valid_q, valid_d;
  logic        req_sent_q, req_sent_d;
  logic        ack_sent_q, ack_sent_d;
  logic        busy_q, busy_d;

  logic        w_accept;
  retry_snap_t w_live_snap;

  assign w_accept                   = valid_q & i_flit_ready;
  assign w_live_snap.num_retry      = retry_num_retry;
  assign w_live_snap.num_phy_reinit = retry_num_phy_reinit;
  assign w_live_snap.eseq           = retry_eseq;
  assign w_live_snap.wrt_ptr        = retry_wrt_ptr;
  assign w_live_snap.num_free_buff  = retry_num_free_buff;
  assign w_live_snap.empty          = retry_set_ack_bit;

  always_comb begin
    state_d     = state_q;
    cur_type_d  = cur_type_q;
    frame_cnt_d = frame_cnt_q;
    snap_d      = snap_q;
    // A pulse for a type already pending or in flight is simply absorbed.
    req_pend_d  = req_pend_q | retry_send_req_seq;
    ack_pend_d  = ack_pend_q | retry_send_ack_seq;
    req_sent_d  = 1'b0;
    ack_sent_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ack_pend_q || req_pend_q) begin
          state_d     = FRAME;
          cur_type_d  = ack_pend_q ? ACK : REQ;
          snap_d      = w_live_snap;
          frame_cnt_d = 4'd0;
        end
      end
      FRAME: begin
        if (w_accept) begin
          if (frame_cnt_q == LAST_FRAME) begin
            state_d     = cur_type_q;
            frame_cnt_d = 4'd0;
          end else begin
            frame_cnt_d = frame_cnt_q + 4'd1;
          end
        end
      end
      REQ: begin
        if (w_accept) begin
          req_sent_d = 1'b1;
          req_pend_d = 1'b0;
          if (ack_pend_q) begin
            state_d    = FRAME;
            cur_type_d = ACK;
            snap_d     = w_live_snap;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ACK: begin
        if (w_accept) begin
          ack_sent_d = 1'b1;
          ack_pend_d = 1'b0;
          if (req_pend_q) begin
            state_d    = FRAME;
            cur_type_d = REQ;
            snap_d     = w_live_snap;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Link loss drops everything, including a flit accepted in the same cycle.
    if (!i_pl_lnk_up) begin
      state_d     = IDLE;
      frame_cnt_d = 4'd0;
      req_pend_d  = 1'b0;
      ack_pend_d  = 1'b0;
      req_sent_d  = 1'b0;
      ack_sent_d  = 1'b0;
    end

    valid_d = (state_d != IDLE);
    busy_d  = valid_d | req_pend_d | ack_pend_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cur_type_q  <= REQ;
      frame_cnt_q <= 4'd0;
      req_pend_q  <= 1'b0;
      ack_pend_q  <= 1'b0;
      snap_q      <= '0;
      valid_q     <= 1'b0;
      req_sent_q  <= 1'b0;
      ack_sent_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_type_q  <= cur_type_d;
      frame_cnt_q <= frame_cnt_d;
      req_pend_q  <= req_pend_d;
      ack_pend_q  <= ack_pend_d;
      snap_q      <= snap_d;
      valid_q     <= valid_d;
      req_sent_q  <= req_sent_d;
      ack_sent_q  <= ack_sent_d;
      busy_q      <= busy_d;
    end
  end

  retry_ctrl_flit_fmt #(
    .FLIT_W (FLIT_W)
  ) u_fmt (
    .i_valid   (valid_q),
    .i_subtype (subtype_of(state_q)),
    .i_snap    (snap_q),
    .o_flit    (o_flit)
  );

  assign o_flit_valid = valid_q;
  assign o_req_sent   = req_sent_q;
  assign o_ack_sent   = ack_sent_q;
  assign o_busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_retry_ctrl_flit_packer.sv
`default_nettype none
// ============================================================================
// tb_retry_ctrl_flit_packer : directed and randomized checks of flit sequencing
// Revision                  : 1.0
// ============================================================================
module tb_retry_ctrl_flit_packer;

  localparam int NF = 5;
  localparam int FW = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lnk_up = 1'b0;
  logic          send_req = 1'b0;
  logic          send_ack = 1'b0;
  logic [4:0]    num_retry = '0;
  logic [4:0]    num_phy = '0;
  logic [7:0]    eseq = '0;
  logic [7:0]    wrt_ptr = '0;
  logic [7:0]    free_buff = '0;
  logic          ack_bit = 1'b0;
  logic          flit_ready = 1'b0;
  logic          o_flit_valid;
  logic [FW-1:0] o_flit;
  logic          o_req_sent;
  logic          o_ack_sent;
  logic          o_busy;

  int            errors = 0;
  int            checks = 0;
  logic [FW-1:0] exp_q[$];
  int            kind_q[$];   // 0 frame, 1 req, 2 ack
  logic [1:0]    cur_mask = 2'b00;

  always #5 clk = ~clk;

  retry_ctrl_flit_packer #(.NUM_FRAMES(NF), .FLIT_W(FW)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_pl_lnk_up          (lnk_up),
    .retry_send_req_seq   (send_req),
    .retry_send_ack_seq   (send_ack),
    .retry_num_retry      (num_retry),
    .retry_num_phy_reinit (num_phy),
    .retry_eseq           (eseq),
    .retry_wrt_ptr        (wrt_ptr),
    .retry_num_free_buff  (free_buff),
    .retry_set_ack_bit    (ack_bit),
    .i_flit_ready         (flit_ready),
    .o_flit_valid         (o_flit_valid),
    .o_flit               (o_flit),
    .o_req_sent           (o_req_sent),
    .o_ack_sent           (o_ack_sent),
    .o_busy               (o_busy)
  );

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference flit built directly from the documented bit layout.
  function automatic logic [FW-1:0] model_flit(input int kind);
    logic [FW-1:0] f;
    f = '0;
    f[0]   = 1'b1;
    f[7:4] = 4'h3;
    if (kind == 0) begin
      f[11:8] = 4'h3;
    end else if (kind == 1) begin
      f[11:8]  = 4'h1;
      f[36:32] = num_retry;
      f[44:40] = num_phy;
      f[55:48] = eseq;
    end else begin
      f[11:8]  = 4'h2;
      f[32]    = ack_bit;
      f[37:33] = num_retry;
      f[44:40] = num_phy;
      f[55:48] = wrt_ptr;
      f[63:56] = free_buff;
    end
    return f;
  endfunction

  task automatic push_seq(input int kind);
    for (int i = 0; i < NF; i++) begin
      exp_q.push_back(model_flit(0));
      kind_q.push_back(0);
    end
    exp_q.push_back(model_flit(kind));
    kind_q.push_back(kind);
  endtask

  task automatic start(input logic [1:0] mask);
    cur_mask = mask;
    send_req = mask[0];
    send_ack = mask[1];
    @(posedge clk); #1;
    send_req = 1'b0;
    send_ack = 1'b0;
  endtask

  // Runs the handshake until the expected flits are consumed (or stop_acc accepts).
  task automatic drain(input int budget, input bit rnd, input int stall_idx, input int stall_len,
                       input int chg_at, input int stop_acc, input int repulse);
    int acc = 0;
    int stall_left = stall_len;
    int pulse_due = 0;
    bit started = 1'b0;
    bit held_v = 1'b0;
    bit done = 1'b0;
    logic [FW-1:0] held = '0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      chk("req_sent", {511'd0, o_req_sent}, {511'd0, pulse_due == 1});
      chk("ack_sent", {511'd0, o_ack_sent}, {511'd0, pulse_due == 2});
      pulse_due = 0;
      if (held_v) chk("hold_flit", o_flit, held);
      if (started && exp_q.size() > 0) chk("no_bubble", {511'd0, o_flit_valid}, {{511{1'b0}}, 1'b1});
      if (stop_acc >= 0 && acc == stop_acc) begin done = 1'b1; break; end
      if (started && exp_q.size() == 0) begin
        chk("busy_end", {511'd0, o_busy}, '0);
        done = 1'b1;
        break;
      end
      if (o_flit_valid) started = 1'b1;
      send_req = (cyc == repulse) && cur_mask[0];
      send_ack = (cyc == repulse) && cur_mask[1];
      if (chg_at >= 0 && acc == chg_at) eseq = 8'h55;
      if (o_flit_valid && acc == stall_idx && stall_left > 0) begin
        flit_ready = 1'b0;
        stall_left--;
      end else if (rnd) begin
        flit_ready = ($urandom_range(0, 3) != 0);
      end else begin
        flit_ready = 1'b1;
      end
      held_v = o_flit_valid && !flit_ready;
      held   = o_flit;
      if (o_flit_valid && flit_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_flit", o_flit, '0);
        end else begin
          chk("flit", o_flit, exp_q.pop_front());
          pulse_due = kind_q.pop_front();
        end
        acc++;
      end
      @(posedge clk); #1;
    end
    send_req = 1'b0;
    send_ack = 1'b0;
    if (!done) chk("drain_timeout", {511'd0, done}, {{511{1'b0}}, 1'b1});
  endtask

  initial begin
    // Reset state
    lnk_up = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {511'd0, o_flit_valid}, '0);
    chk("rst_flit", o_flit, '0);
    chk("rst_busy", {511'd0, o_busy}, '0);
    chk("rst_req_sent", {511'd0, o_req_sent}, '0);
    chk("rst_ack_sent", {511'd0, o_ack_sent}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single Req
    num_retry = 5'd3; num_phy = 5'd1; eseq = 8'h2A;
    push_seq(1);
    start(2'b01);
    drain(60, 1'b0, -1, 0, -1, -1, -1);

    // Backpressure on the third frame
    push_seq(1);
    start(2'b01);
    drain(60, 1'b0, 2, 4, -1, -1, -1);

    // Simultaneous Req and Ack: Ack goes first
    wrt_ptr = 8'h10; free_buff = 8'h40; ack_bit = 1'b1;
    push_seq(2);
    push_seq(1);
    start(2'b11);
    drain(80, 1'b0, -1, 0, -1, -1, -1);

    // Fields change mid-sequence; the snapshot holds
    eseq = 8'h2A;
    push_seq(1);
    start(2'b01);
    drain(60, 1'b0, -1, 0, 2, -1, -1);
    eseq = 8'h2A;

    // Pulses while the link is down are dropped
    lnk_up = 1'b0;
    start(2'b11);
    lnk_up = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("lnkdn_pulse_valid", {511'd0, o_flit_valid}, '0);
    chk("lnkdn_pulse_busy", {511'd0, o_busy}, '0);

    // Link drop mid-FRAME, then a full restart
    push_seq(1);
    start(2'b01);
    drain(60, 1'b0, -1, 0, -1, 2, -1);
    lnk_up = 1'b0;
    exp_q.delete();
    kind_q.delete();
    @(posedge clk); #1;
    lnk_up = 1'b1;
    chk("lnkdrop_valid", {511'd0, o_flit_valid}, '0);
    chk("lnkdrop_busy", {511'd0, o_busy}, '0);
    for (int i = 0; i < 4; i++) begin
      chk("lnkdrop_no_sent", {510'd0, o_req_sent, o_ack_sent}, '0);
      chk("lnkdrop_idle", {511'd0, o_flit_valid}, '0);
      @(posedge clk); #1;
    end
    push_seq(1);
    start(2'b01);
    drain(60, 1'b0, -1, 0, -1, -1, -1);

    // Async reset while the Ack flit is presented
    ack_bit = 1'b0; wrt_ptr = 8'hC3; free_buff = 8'h07;
    push_seq(2);
    start(2'b10);
    drain(60, 1'b0, -1, 0, -1, NF, -1);
    flit_ready = 1'b0;
    chk("pre_rst_ack_flit", o_flit, exp_q[0]);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {511'd0, o_flit_valid}, '0);
    chk("arst_flit", o_flit, '0);
    chk("arst_busy", {511'd0, o_busy}, '0);
    exp_q.delete();
    kind_q.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    flit_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_ack", {511'd0, o_ack_sent}, '0);
      chk("post_rst_idle", {511'd0, o_flit_valid}, '0);
    end

    // Randomized groups with absorbed duplicate pulses
    for (int g = 0; g < 12; g++) begin
      logic [1:0] m;
      num_retry = 5'($urandom); num_phy = 5'($urandom); eseq = 8'($urandom);
      wrt_ptr = 8'($urandom); free_buff = 8'($urandom); ack_bit = 1'($urandom);
      m = 2'($urandom_range(1, 3));
      if (m[1]) push_seq(2);
      if (m[0]) push_seq(1);
      start(m);
      drain(400, 1'b1, -1, 0, -1, -1, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
